// File: rtl/spi_mem_master.sv
// spi_mem_master: one 32-bit word read/write to SPI serial storage,
// SPI mode 0, frame {cmd, addr[23:0], data}, MSB first.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_write/addr/wdata  request fields, sampled at acceptance
//   resp_valid/rdata  one-cycle completion pulse, read data
//   spi_cs_n/sclk/mosi/miso  serial storage pins
module spi_mem_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [7:0] LP_DIV_END = 8'(CLK_DIV - 1);
  localparam logic [6:0] LP_BIT_END = 7'd63;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_div;
  logic [6:0]  r_bit;
  logic [63:0] r_shift;
  logic [31:0] r_rx;
  logic [31:0] r_rdata;
  logic        r_write;
  logic        r_cs_n;
  logic        r_sclk;
  logic        r_mosi;

  logic        w_accept;
  logic        w_div_end;
  logic        w_rise;
  logic        w_fall;
  logic        w_last;
  logic [7:0]  w_cmd;
  logic [63:0] w_frame;
  logic        w_unused_addr;

  assign w_unused_addr = ^req_addr[31:24];

  assign w_accept  = req_valid && req_ready;
  assign w_div_end = (r_div == LP_DIV_END);
  assign w_rise    = (r_state == S_SHIFT) && !r_sclk && w_div_end;
  assign w_fall    = (r_state == S_SHIFT) && r_sclk && w_div_end;
  assign w_last    = w_fall && (r_bit == LP_BIT_END);

  assign w_cmd   = req_write ? 8'h02 : 8'h03;
  assign w_frame = {w_cmd, req_addr[23:0],
                    req_write ? req_wdata : 32'h0};

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_SETUP;
      S_SETUP: if (w_div_end) w_next = S_SHIFT;
      S_SHIFT: if (w_last)    w_next = S_HOLD;
      S_HOLD:  if (w_div_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs; ready is masked while reset is held
  always_comb begin
    req_ready  = rst && (r_state == S_IDLE);
    resp_valid = (r_state == S_DONE);
  end

  // datapath: counters, shifter, pins, read data
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div   <= 8'd0;
      r_bit   <= 7'd0;
      r_shift <= 64'h0;
      r_rx    <= 32'h0;
      r_rdata <= 32'h0;
      r_write <= 1'b0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_shift <= w_frame;
            r_mosi  <= w_frame[63];
            r_cs_n  <= 1'b0;
            r_div   <= 8'd0;
            r_bit   <= 7'd0;
          end
        end
        S_SETUP: begin
          r_div <= w_div_end ? 8'd0 : r_div + 8'd1;
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_div  <= 8'd0;
            r_sclk <= !r_sclk;
          end else begin
            r_div <= r_div + 8'd1;
          end
          if (w_rise) begin
            r_rx <= {r_rx[30:0], spi_miso};
          end
          // no mosi update after the final period
          if (w_fall && !w_last) begin
            r_bit   <= r_bit + 7'd1;
            r_shift <= r_shift << 1;
            r_mosi  <= r_shift[62];
          end
        end
        S_HOLD: begin
          r_div <= w_div_end ? 8'd0 : r_div + 8'd1;
          if (w_div_end) begin
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_rdata <= r_write ? 32'h0 : r_rx;
          end
        end
        S_DONE: begin
          r_div <= 8'd0;
        end
        default: begin
          r_cs_n <= 1'b1;
          r_sclk <= 1'b0;
        end
      endcase
    end
  end

  assign resp_rdata = r_rdata;
  assign spi_cs_n   = r_cs_n;
  assign spi_sclk   = r_sclk;
  assign spi_mosi   = r_mosi;

endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master: directed bench for spi_mem_master,
// CLK_DIV=2 instance (a_*) and CLK_DIV=1 instance (b_*).
module tb_spi_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_valid = 1'b0;
  logic        a_ready;
  logic        a_write = 1'b0;
  logic [31:0] a_addr  = 32'h0;
  logic [31:0] a_wdata = 32'h0;
  logic        a_rvalid;
  logic [31:0] a_rdata;
  logic        a_cs_n;
  logic        a_sclk;
  logic        a_mosi;
  logic        a_miso;

  logic        b_valid = 1'b0;
  logic        b_ready;
  logic        b_write = 1'b0;
  logic [31:0] b_addr  = 32'h0;
  logic [31:0] b_wdata = 32'h0;
  logic        b_rvalid;
  logic [31:0] b_rdata;
  logic        b_cs_n;
  logic        b_sclk;
  logic        b_mosi;
  logic        b_miso;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_mem_master #(.CLK_DIV(2)) u_a (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (a_valid),
    .req_ready  (a_ready),
    .req_write  (a_write),
    .req_addr   (a_addr),
    .req_wdata  (a_wdata),
    .resp_valid (a_rvalid),
    .resp_rdata (a_rdata),
    .spi_cs_n   (a_cs_n),
    .spi_sclk   (a_sclk),
    .spi_mosi   (a_mosi),
    .spi_miso   (a_miso)
  );

  spi_mem_master #(.CLK_DIV(1)) u_b (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (b_valid),
    .req_ready  (b_ready),
    .req_write  (b_write),
    .req_addr   (b_addr),
    .req_wdata  (b_wdata),
    .resp_valid (b_rvalid),
    .resp_rdata (b_rdata),
    .spi_cs_n   (b_cs_n),
    .spi_sclk   (b_sclk),
    .spi_mosi   (b_mosi),
    .spi_miso   (b_miso)
  );

  // slave models: count sclk rises since cs_n fell, capture mosi,
  // serve pattern bit (63 - rises) on miso
  logic [63:0] pat_a = 64'h0;
  logic [63:0] mo_a  = 64'h0;
  int          rc_a  = 0;
  int          rl_a  = 0;
  int          acc_a = 0;

  always @(posedge a_cs_n or posedge a_sclk) begin
    if (a_cs_n) begin
      rc_a <= 0;
    end else begin
      rc_a <= rc_a + 1;
      rl_a <= rc_a + 1;
      mo_a <= {mo_a[62:0], a_mosi};
    end
  end
  assign a_miso = (rc_a < 64) ? pat_a[6'(63 - rc_a)] : 1'b0;

  always @(posedge clk) begin
    if (a_valid && a_ready) acc_a <= acc_a + 1;
  end

  logic [63:0] pat_b = 64'h0;
  logic [63:0] mo_b  = 64'h0;
  int          rc_b  = 0;
  int          rl_b  = 0;

  always @(posedge b_cs_n or posedge b_sclk) begin
    if (b_cs_n) begin
      rc_b <= 0;
    end else begin
      rc_b <= rc_b + 1;
      rl_b <= rc_b + 1;
      mo_b <= {mo_b[62:0], b_mosi};
    end
  end
  assign b_miso = (rc_b < 64) ? pat_b[6'(63 - rc_b)] : 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // lat = index of the posedge after which resp_valid is seen,
  // counting the accepting edge as edge 1
  task automatic txn_a(input logic wr,
                       input logic [31:0] ad,
                       input logic [31:0] wd,
                       output int lat);
    @(negedge clk);
    a_valid = 1'b1;
    a_write = wr;
    a_addr  = ad;
    a_wdata = wd;
    for (int i = 0; i < 20 && !a_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (a_rvalid) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int acc0;
    int gap;
    int nrv;

    // reset held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n",   64'(a_cs_n),   64'h1);
    chk("rst_sclk",   64'(a_sclk),   64'h0);
    chk("rst_mosi",   64'(a_mosi),   64'h0);
    chk("rst_rvalid", 64'(a_rvalid), 64'h0);
    chk("rst_rdata",  64'(a_rdata),  64'h0);
    chk("rst_ready",  64'(a_ready),  64'h0);
    chk("rst_ready_b", 64'(b_ready), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready",   64'(a_ready), 64'h1);
    chk("rel_ready_b", 64'(b_ready), 64'h1);

    // read, CLK_DIV=2; upper 32 miso bits are junk to discard
    pat_a = {32'h5A5A_C3C3, 32'hDEAD_BEEF};
    txn_a(1'b0, 32'h0000_2004, 32'hFFFF_FFFF, lat);
    chk("rd_lat",   64'(lat),          64'd261);
    chk("rd_rdata", 64'(a_rdata),      64'hDEAD_BEEF);
    chk("rd_cmd",   64'(mo_a[63:56]),  64'h03);
    chk("rd_addr",  64'(mo_a[55:32]),  64'h00_2004);
    chk("rd_data",  64'(mo_a[31:0]),   64'h0);
    chk("rd_rises", 64'(rl_a),         64'd64);

    // write; upper address bits must not reach the wire
    pat_a = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    txn_a(1'b1, 32'hFF00_0010, 32'h1234_5678, lat);
    chk("wr_lat",   64'(lat),         64'd261);
    chk("wr_rdata", 64'(a_rdata),     64'h0);
    chk("wr_cmd",   64'(mo_a[63:56]), 64'h02);
    chk("wr_addr",  64'(mo_a[55:32]), 64'h00_0010);
    chk("wr_data",  64'(mo_a[31:0]),  64'h1234_5678);

    // req_valid held: one access, then DONE + IDLE with cs_n high
    pat_a = {32'h0, 32'h0BAD_F00D};
    @(negedge clk);
    acc0    = acc_a;
    a_valid = 1'b1;
    a_write = 1'b0;
    a_addr  = 32'h0000_0100;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (a_rvalid) break;
    end
    chk("b2b_rvalid", 64'(a_rvalid),     64'h1);
    chk("b2b_one",    64'(acc_a - acc0), 64'd1);
    chk("b2b_rdata",  64'(a_rdata),      64'h0BAD_F00D);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      if (!a_cs_n) break;
      gap++;
      @(negedge clk);
    end
    a_valid = 1'b0;
    chk("b2b_gap", 64'(gap),           64'd2);
    chk("b2b_two", 64'(acc_a - acc0),  64'd2);
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (a_rvalid) break;
    end
    chk("b2b_rvalid2", 64'(a_rvalid), 64'h1);

    // reset during SHIFT bit 20
    pat_a = {32'h0, 32'h1111_2222};
    @(negedge clk);
    a_valid = 1'b1;
    a_write = 1'b0;
    a_addr  = 32'h0000_0040;
    for (int i = 0; i < 20 && !a_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rc_a == 20) break;
    end
    chk("ab_bit", 64'(rc_a), 64'd20);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ab_cs_n",   64'(a_cs_n),   64'h1);
    chk("ab_sclk",   64'(a_sclk),   64'h0);
    chk("ab_rvalid", 64'(a_rvalid), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    nrv = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (a_rvalid) nrv++;
    end
    chk("ab_no_resp", 64'(nrv), 64'd0);

    pat_a = {32'h7777_7777, 32'h8765_4321};
    txn_a(1'b0, 32'h00AB_CDEF, 32'h0, lat);
    chk("ab_rd_lat",   64'(lat),         64'd261);
    chk("ab_rd_rdata", 64'(a_rdata),     64'h8765_4321);
    chk("ab_rd_addr",  64'(mo_a[55:32]), 64'hAB_CDEF);

    // CLK_DIV=1 read
    pat_b = {32'hFFFF_0000, 32'hCAFE_F00D};
    @(negedge clk);
    b_valid = 1'b1;
    b_write = 1'b0;
    b_addr  = 32'h0000_0010;
    for (int i = 0; i < 20 && !b_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    lat = 1;
    nrv = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (b_sclk) nrv++;
      if (b_rvalid) break;
    end
    chk("d1_lat",   64'(lat),         64'd131);
    chk("d1_rdata", 64'(b_rdata),     64'hCAFE_F00D);
    chk("d1_rises", 64'(rl_b),        64'd64);
    chk("d1_high",  64'(nrv),         64'd64);
    chk("d1_cmd",   64'(mo_b[63:56]), 64'h03);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
